bb_slave_port: RTL and testbench
================================

Name: bb_slave_port

Overview:
- Bus-side slave endpoint on the serial system bus. It is the downstream consumer of the serial transactions driven by the bus master port.
- Decodes the serial 16-bit address, MSB first: a 6-bit device ID, then a 10-bit local address.
- Acknowledges only its own ID. Collects serial write data, or fetches and serialises read data from a local memory/peripheral.
- Asserts split when the local read latency is long.

Parameters:
- DEVICE_ID, 6'd0: matched against address bits [15:10].
- SPLIT_THRESHOLD, 4: cycles waiting on mem_rvalid before split asserts (>=1).
- MEM_AW, 10: local address width. Fixed at 16-6; a parameter for documentation only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mode  in  1  1=write, 0=read; held constant by master for the whole transaction
- wr_bus  in  1  serial address/write-data bit from master
- rd_bus  out  1  serial read-data bit to master
- ack  out  1  device-ID match, valid on the 6th address bit
- master_valid  in  1  master is presenting an address or write bit
- slave_ready  out  1  slave accepts a bit this cycle
- master_ready  in  1  master is accepting read bits
- slave_valid  out  1  rd_bus holds a valid read bit
- split  out  1  slave is holding the bus pending local read data
- mem_addr  out  10  local address
- mem_wdata  out  8  write data
- mem_wr  out  1  one-cycle write strobe
- mem_rd  out  1  one-cycle read strobe
- mem_rdata  in  8  read data
- mem_rvalid  in  1  mem_rdata valid; single-cycle pulse

Behaviour:
- Reset: synchronous. While rst=1:
  - state=IDLE; all counters and shift registers cleared.
  - ack, slave_ready, slave_valid, split, mem_wr, mem_rd, rd_bus = 0; mem_addr=0, mem_wdata=0.
- Bit transfer: a bit is taken when master_valid & slave_ready, in the same cycle. Every bit is MSB first.
- States:
  - IDLE/ADDR_DEV (slave_ready=1):
    - Shift wr_bus into a 6-bit register; bit_cnt++.
    - master_valid low clears bit_cnt.
    - On the 6th bit (bit_cnt==5 & master_valid), ack is combinational: {dev_sr[4:0],wr_bus}==DEVICE_ID.
    - Match -> ADDR_MEM with bit_cnt=0. Mismatch -> UNSEL.
  - UNSEL (slave_ready=0): wait for master_valid==0, then -> IDLE. This ignores the remainder of a transaction addressed to another slave.
  - ADDR_MEM (slave_ready=1):
    - Shift 10 bits into mem_addr.
    - After the 10th bit: mode=1 -> WR_DATA; mode=0 -> MEM_READ. Mode is sampled on the 10th bit.
  - WR_DATA (slave_ready=1): shift 8 bits into mem_wdata; after the 8th -> MEM_WRITE.
  - MEM_WRITE: mem_wr=1 for exactly one cycle with stable mem_addr/mem_wdata -> IDLE.
  - MEM_READ: mem_rd=1 for one cycle; wait_cnt=0 -> RD_WAIT.
  - RD_WAIT:
    - mem_rvalid -> latch mem_rdata into rd_sr, deassert split, -> RD_DATA.
    - Otherwise wait_cnt++; split goes to 1 (registered) the cycle after wait_cnt reaches SPLIT_THRESHOLD-1, and stays 1 until mem_rvalid.
  - RD_DATA:
    - rd_bus=rd_sr[7]; slave_valid=1.
    - Each cycle with master_ready & slave_valid: shift rd_sr left, bit_cnt++.
    - After the 8th bit -> IDLE, slave_valid=0.
- Abort: master_valid==0 in ADDR_MEM or WR_DATA -> IDLE. No mem strobe is issued and partial data is discarded.
  - This covers master timeout/restart; the master keeps master_valid continuous between its address and write phases.
- mem_rvalid outside RD_WAIT is ignored.
- mem_addr/mem_wdata hold their last values until the next transaction overwrites them.
- split never asserts during write transactions.

Test Plan:
1. Write, DEVICE_ID=6'h05: master sends addr 16'h1555, mode=1, data 8'hA7.
   -> ack=1 on the 6th bit; mem_wr pulses exactly once with mem_addr=10'h155, mem_wdata=8'hA7; state IDLE after.
2. Read, fast memory (mem_rvalid 1 cycle after mem_rd, data 8'h3C): addr 16'h1402, mode=0.
   -> mem_rd pulses once with mem_addr=10'h002; split stays 0; rd_bus emits 0,0,1,1,1,1,0,0 on 8 slave_valid&master_ready cycles.
3. Read, slow memory (mem_rvalid 10 cycles after mem_rd, data 8'hF0), SPLIT_THRESHOLD=4.
   -> split=1 from 4 cycles after RD_WAIT entry until the mem_rvalid cycle; then 8 bits 1,1,1,1,0,0,0,0 are delivered.
4. ID mismatch: addr 16'hFC00 to DEVICE_ID=5.
   -> ack=0 on the 6th bit; state UNSEL; no mem strobes; back in IDLE once master_valid drops.
   -> A following matching write completes normally.
5. Abort: master_valid drops after 4 ADDR_MEM bits, then a full write to addr 16'h1401, data 8'h11.
   -> no strobe for the aborted transaction; exactly one mem_wr with 10'h001/8'h11.
6. Reset mid-RD_DATA (rst=1 for 1 cycle after 3 bits sent).
   -> the next cycle has slave_valid=0, split=0, state IDLE; a subsequent read works.

Source files
------------

// File: rtl/bb_slave_port.sv
// Serial system-bus slave endpoint: decodes a 6-bit device ID plus a 10-bit local address,
// then either collects write data or fetches and serialises read data from local memory.
module bb_slave_port #(
    parameter logic [5:0] DEVICE_ID       = 6'd0,
    parameter int         SPLIT_THRESHOLD = 4,
    parameter int         MEM_AW          = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              wr_bus,
    output logic              rd_bus,
    output logic              ack,
    input  logic              master_valid,
    output logic              slave_ready,
    input  logic              master_ready,
    output logic              slave_valid,
    output logic              split,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid
);

    localparam int WCW = $clog2(SPLIT_THRESHOLD + 1) + 1;

    typedef enum logic [2:0] {
        IDLE, UNSEL, ADDR_MEM, WR_DATA, MEM_WRITE, MEM_READ, RD_WAIT, RD_DATA
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [4:0]        dev_sr_q, dev_sr_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]        rd_sr_q, rd_sr_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic              split_q, split_d;
    logic              mem_wr_q, mem_rd_q, slave_valid_q;
    logic              dev_match;

    assign dev_match   = ({dev_sr_q, wr_bus} == DEVICE_ID);
    assign slave_ready = !rst && (state_q == IDLE || state_q == ADDR_MEM || state_q == WR_DATA);
    assign rd_bus      = rd_sr_q[7] & slave_valid_q;
    assign slave_valid = slave_valid_q;
    assign split       = split_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wr      = mem_wr_q;
    assign mem_rd      = mem_rd_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        dev_sr_d    = dev_sr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_sr_d     = rd_sr_q;
        wait_cnt_d  = wait_cnt_q;
        split_d     = split_q;
        ack         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (master_valid) begin
                    dev_sr_d = {dev_sr_q[3:0], wr_bus};
                    if (bit_cnt_q == 4'd5) begin
                        ack       = !rst && dev_match;
                        bit_cnt_d = 4'd0;
                        state_d   = dev_match ? ADDR_MEM : UNSEL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    bit_cnt_d = 4'd0;
                end
            end
            UNSEL: begin
                if (!master_valid) state_d = IDLE;
            end
            ADDR_MEM: begin
                if (!master_valid) begin
                    bit_cnt_d = 4'd0;
                    state_d   = IDLE;
                end else begin
                    mem_addr_d = {mem_addr_q[MEM_AW-2:0], wr_bus};
                    if (bit_cnt_q == 4'(MEM_AW - 1)) begin
                        bit_cnt_d = 4'd0;
                        state_d   = mode ? WR_DATA : MEM_READ;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            WR_DATA: begin
                if (!master_valid) begin
                    bit_cnt_d = 4'd0;
                    state_d   = IDLE;
                end else begin
                    mem_wdata_d = {mem_wdata_q[6:0], wr_bus};
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        state_d   = MEM_WRITE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            MEM_WRITE: state_d = IDLE;
            MEM_READ: begin
                wait_cnt_d = '0;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    rd_sr_d   = mem_rdata;
                    split_d   = 1'b0;
                    bit_cnt_d = 4'd0;
                    state_d   = RD_DATA;
                end else if (wait_cnt_q == WCW'(SPLIT_THRESHOLD - 1)) begin
                    // Counter parks at the threshold; split stays latched until data returns.
                    split_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RD_DATA: begin
                if (master_ready) begin
                    rd_sr_d = {rd_sr_q[6:0], 1'b0};
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            dev_sr_q      <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd_sr_q       <= '0;
            wait_cnt_q    <= '0;
            split_q       <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            slave_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            dev_sr_q      <= dev_sr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rd_sr_q       <= rd_sr_d;
            wait_cnt_q    <= wait_cnt_d;
            split_q       <= split_d;
            mem_wr_q      <= (state_d == MEM_WRITE);
            mem_rd_q      <= (state_d == MEM_READ);
            slave_valid_q <= (state_d == RD_DATA);
        end
    end

endmodule

// File: tb/tb_bb_slave_port.sv
// Directed plus randomized bench for bb_slave_port, driving a serial master and a
// latency-configurable memory, checked against a byte-array memory model.
module tb_bb_slave_port;

    localparam logic [5:0] DEV = 6'h05;
    localparam int         TH  = 4;

    logic       clk = 1'b0;
    logic       rst, mode, wr_bus, master_valid, master_ready, mem_rvalid;
    logic [7:0] mem_rdata;
    logic       rd_bus, ack, slave_ready, slave_valid, split, mem_wr, mem_rd;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;

    always #5 clk = ~clk;

    bb_slave_port #(.DEVICE_ID(DEV), .SPLIT_THRESHOLD(TH), .MEM_AW(10)) dut (
        .clk(clk), .rst(rst), .mode(mode), .wr_bus(wr_bus), .rd_bus(rd_bus), .ack(ack),
        .master_valid(master_valid), .slave_ready(slave_ready), .master_ready(master_ready),
        .slave_valid(slave_valid), .split(split), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] ref_mem [1024];
    logic [7:0] phys_mem [1024];
    int lat_cfg = 1;
    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, split_cnt = 0, split_first = 0, rd_cyc = 0;
    logic [9:0] wr_addr_seen, rd_addr_seen;
    logic [7:0] wr_data_seen;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus-side monitor, sampled mid-cycle; mem_wr also updates the physical memory.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (mem_wr === 1'b1) begin
            wr_cnt++;
            wr_addr_seen = mem_addr;
            wr_data_seen = mem_wdata;
            phys_mem[mem_addr] = mem_wdata;
        end
        if (mem_rd === 1'b1) begin
            rd_cnt++;
            rd_addr_seen = mem_addr;
            rd_cyc = cyc;
        end
        if (split === 1'b1) begin
            if (split_cnt == 0) split_first = cyc;
            split_cnt++;
        end
    end

    // Memory responder: returns data lat_cfg cycles after the mem_rd cycle.
    initial begin
        logic [9:0] a;
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                a = mem_addr;
                @(posedge clk);
                repeat (lat_cfg - 1) @(posedge clk);
                #1 mem_rvalid = 1'b1;
                mem_rdata = phys_mem[a];
                @(posedge clk);
                #1 mem_rvalid = 1'b0;
                mem_rdata = 8'($urandom);
            end
        end
    end

    task automatic send_header(input logic [15:0] addr, input logic m);
        logic sel;
        sel  = (addr[15:10] == DEV);
        mode = m;
        for (int i = 0; i < 16; i++) begin
            master_valid = 1'b1;
            wr_bus = addr[15-i];
            @(negedge clk);
            if ((i < 6 || sel) && slave_ready !== 1'b1) check_output("addr_ready", slave_ready, 1);
            if (i == 5) check_output("ack", ack, sel);
            if (!sel && i == 6) check_output("unsel_ready", slave_ready, 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_data(input logic [7:0] data);
        for (int i = 0; i < 8; i++) begin
            master_valid = 1'b1;
            wr_bus = data[7-i];
            @(negedge clk);
            if (slave_ready !== 1'b1) check_output("data_ready", slave_ready, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic recv_bits(input int n, input bit stall, output logic [7:0] v, output int got);
        int k;
        v = 8'h00;
        got = 0;
        k = 0;
        while (got < n && k < 400) begin
            master_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (slave_valid === 1'b1 && master_ready) begin
                v = {v[6:0], rd_bus};
                got++;
            end
            @(posedge clk);
            #1;
            k++;
        end
        master_ready = 1'b0;
        if (got < n) check_output("rd_bits", got, n);
    endtask

    // One full transaction from the master's side, with all end-of-transaction checks.
    task automatic apply_stimulus(input logic [15:0] addr, input logic m, input logic [7:0] data,
                                  input int lat, input bit stall);
        logic sel;
        int w0, r0, got, exp_split;
        logic [7:0] v;
        sel = (addr[15:10] == DEV);
        w0 = wr_cnt;
        r0 = rd_cnt;
        split_cnt = 0;
        lat_cfg = lat;
        send_header(addr, m);
        if (sel && m) begin
            send_data(data);
            ref_mem[addr[9:0]] = data;
        end
        master_valid = 1'b0;
        wr_bus = 1'b0;
        if (sel && !m) begin
            recv_bits(8, stall, v, got);
            check_output("rd_byte", v, ref_mem[addr[9:0]]);
        end
        repeat (3) @(posedge clk);
        #1;
        check_output("wr_count", wr_cnt - w0, (sel && m) ? 1 : 0);
        check_output("rd_count", rd_cnt - r0, (sel && !m) ? 1 : 0);
        if (sel && m) begin
            check_output("wr_addr", wr_addr_seen, addr[9:0]);
            check_output("wr_data", wr_data_seen, data);
        end
        if (sel && !m) begin
            exp_split = (lat > TH) ? lat - TH : 0;
            check_output("rd_addr", rd_addr_seen, addr[9:0]);
            check_output("split_cycles", split_cnt, exp_split);
            if (exp_split > 0) check_output("split_start", split_first, rd_cyc + 1 + TH);
        end
        if (m) check_output("split_on_write", split_cnt, 0);
        check_output("idle_ready", slave_ready, 1);
        check_output("idle_valid", slave_valid, 0);
    endtask

    initial begin
        logic [7:0] v;
        int got, w0, r0;
        logic [5:0] id;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]  = 8'($urandom);
            phys_mem[i] = ref_mem[i];
        end
        ref_mem[10'h002] = 8'h3C; phys_mem[10'h002] = 8'h3C;
        ref_mem[10'h010] = 8'hF0; phys_mem[10'h010] = 8'hF0;
        rst = 1'b1; mode = 1'b0; wr_bus = 1'b0; master_valid = 1'b0; master_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_ready", slave_ready, 0);
        check_output("rst_valid", slave_valid, 0);
        check_output("rst_split", split, 0);
        check_output("rst_strobes", {ack, mem_wr, mem_rd, rd_bus}, 4'b0000);
        check_output("rst_addr", mem_addr, 0);
        check_output("rst_wdata", mem_wdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] write, read fast, read slow");
        apply_stimulus(16'h1555, 1'b1, 8'hA7, 1, 0);
        apply_stimulus(16'h1402, 1'b0, 8'h00, 1, 0);
        apply_stimulus(16'h1410, 1'b0, 8'h00, 10, 0);

        $display("[TB] id mismatch then matching write");
        apply_stimulus(16'hFC00, 1'b1, 8'h5A, 1, 0);
        apply_stimulus(16'h1423, 1'b1, 8'hC3, 1, 0);

        $display("[TB] abort after 4 local address bits");
        w0 = wr_cnt;
        r0 = rd_cnt;
        mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            master_valid = 1'b1;
            wr_bus = (i == 3 || i == 5 || i == 7);
            @(posedge clk);
            #1;
        end
        master_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_output("abort_no_strobe", (wr_cnt - w0) + (rd_cnt - r0), 0);
        apply_stimulus(16'h1401, 1'b1, 8'h11, 1, 0);

        $display("[TB] reset during read data");
        lat_cfg = 1;
        send_header(16'h1402, 1'b0);
        master_valid = 1'b0;
        recv_bits(3, 0, v, got);
        check_output("pre_rst_bits", v[2:0], 3'b001);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("post_rst_valid", slave_valid, 0);
        check_output("post_rst_split", split, 0);
        check_output("post_rst_ready", slave_ready, 1);
        @(posedge clk);
        #1;
        apply_stimulus(16'h1410, 1'b0, 8'h00, 6, 1);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 30; t++) begin
            id = ($urandom_range(0, 3) == 0) ? 6'($urandom) : DEV;
            apply_stimulus({id, 6'd0, 4'($urandom)}, 1'($urandom), 8'($urandom),
                           $urandom_range(1, 12), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
